uart_fifo_ctrl: RTL
===================

// Module: uart_fifo_ctrl
// PURPOSE
//  Memory-mapped UART peripheral with TX/RX FIFOs, configurable parity, stop bits and baud divisor.
//  Sits on the CPU data-memory bus beside the other peripherals and is fully synchronous to clk;
//  the baud tick is a clock enable, never a clock. Reports framing, parity and overrun errors as sticky flags.
// PARAMETERS
//  DBIT        8    data bits per frame (5..8)
//  FIFO_DEPTH  16   entries per TX and RX FIFO (power of two, >=2)
//  DVSR_W      11   baud divisor width; tick period = dvsr+1 clk cycles (16x oversample)
//  SB_TICK     16   ticks per stop bit (16 = 1 stop bit; 2-stop mode doubles it)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  cpu_address  in   32  byte address; only [4:0] decoded
//  cpu_data     in   32  write data
//  write_enable in   1   register write strobe
//  read_enable  in   1   register read strobe (pops RX FIFO at RXDATA)
//  rx           in   1   serial input, asynchronous
//  cout         out  32  read data, combinational from cpu_address and register state
//  tx           out  1   serial output, idle high
//  irq          out  1   (rx_ie & !rx_empty) | (tx_ie & tx_empty) | any sticky error
// BEHAVIOUR
//  Map: 0x00 TXDATA W (push [DBIT-1:0]); 0x04 RXDATA R (pop, data in [DBIT-1:0]);
//   0x08 STATUS R/W1C {.., ovr[6], perr[5], ferr[4], rx_full[3], rx_empty[2], tx_full[1], tx_empty[0]};
//   0x0C CTRL RW {tx_ie[22], rx_ie[21], stop2[20], par_odd[19], par_en[18], .., dvsr[DVSR_W-1:0]}.
//  Reset: tx=1, irq=0, CTRL=0, sticky errors=0, both FIFOs empty, FSMs idle; cout=STATUS at 0x08 -> 0x5.
//  Unmapped/unstrobed reads return 0 except as decoded; read of empty RXDATA returns 0, no pop.
//  Push to full TX FIFO is discarded, no flag. FIFO pointers wrap mod FIFO_DEPTH; count width log2+1.
//  Baud gen: counter 0..dvsr, tick one clk when counter==dvsr; dvsr==0 -> no ticks (UART halted).
//  CTRL write resets the baud counter to 0 on the next cycle.
//  rx passes a 2-flop synchroniser (reset value 1) before the RX FSM.
//  RX FSM IDLE->START on sync rx==0; START: at tick 7 rx still 0 -> DATA, else IDLE (glitch);
//   DATA: sample every 16 ticks, LSB first, DBIT bits; PARITY (if par_en): 16 ticks, check even/odd;
//   STOP: SB_TICK (x2 if stop2) ticks, sample stop level at first stop bit middle;
//   done: push byte unless RX FIFO full -> drop byte, set ovr; stop==0 sets ferr; parity mismatch sets perr.
//   Byte with ferr/perr is still pushed. Pushed data visible at RXDATA the cycle after done.
//  TX FSM IDLE: on tick with TX FIFO non-empty pop and -> START (tx=0, 16 ticks) -> DATA (DBIT x16,
//   LSB first) -> PARITY (if par_en) -> STOP (tx=1, SB_TICK or 2*SB_TICK) -> IDLE.
//  TX latency: first start edge on tx within dvsr+2 clks of push into empty FIFO with FSM idle.
//  CPU push and TX pop same cycle: both occur; count unchanged. Same for RX pop/push; on full RX FIFO a
//   simultaneous pop frees the slot and the new byte is accepted (no overrun).
//  STATUS W1C: bit=1 clears sticky flag; hardware set in the same cycle wins.
//  CTRL changes mid-frame take effect immediately (software must drain first); not checked.
//  Reset mid-frame: tx returns to 1 next cycle, partial bytes and FIFO contents lost.
// STRUCTURE
//  uart_pkg: register offset localparams, STATUS/CTRL bit index constants, rx/tx state enums.
//  Sub-module uart_sync_fifo #(WIDTH,DEPTH): push/pop/full/empty/count, same-cycle push+pop legal,
//   instantiated twice. Baud gen, RX FSM, TX FSM and register decode stay in this module.
// TESTING
//  dvsr=0x00A, 8N1, push 0xA5 -> tx frame 0,1,0,1,0,0,1,0,1,1 each 176 clks; tx_empty set at end.
//  Loopback tx->rx, push 0x00,0xFF,0x3C -> RXDATA reads same order; rx_empty=1 after third read.
//  par_en=1 par_odd=1, inject 0x01 with wrong parity bit -> perr=1, byte 0x01 pushed; W1C 0x20 -> perr=0.
//  Inject FIFO_DEPTH+1 bytes without reads -> rx_full=1, ovr=1, first 16 bytes intact, 17th lost.
//  Stop bit driven 0 -> ferr=1; 3-clk low glitch on rx -> no byte, FSM back to IDLE.
//  Reset asserted mid-TX-data-bit -> tx=1 next clk, STATUS reads 0x5, no further frame bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, bit positions and FSM state types for the UART peripheral.
package uart_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_FERR     = 4;
  localparam int ST_PERR     = 5;
  localparam int ST_OVR      = 6;
  // FIFO fill levels occupy otherwise unused STATUS bits
  localparam int ST_RX_LEVEL = 8;
  localparam int ST_TX_LEVEL = 16;

  localparam int CT_PAR_EN  = 18;
  localparam int CT_PAR_ODD = 19;
  localparam int CT_STOP2   = 20;
  localparam int CT_RX_IE   = 21;
  localparam int CT_TX_IE   = 22;

  localparam int BIT_TICKS = 16;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; push and pop in the same cycle are both honoured, even when full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART: baud tick enable, 16x oversampled RX/TX FSMs, TX/RX FIFOs, sticky error flags.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DVSR_W     = 11,
  parameter int SB_TICK    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_data,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic        rx,
  output logic [31:0] cout,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(2 * SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [31:0] CTRL_MASK = (32'h1F << CT_PAR_EN) | ((32'h1 << DVSR_W) - 32'h1);

  logic [4:0]        addr;
  logic              wr_tx, wr_ctrl, wr_status, rd_rx;
  logic [31:0]       ctrl_q;
  logic [DVSR_W-1:0] dvsr, baud_cnt;
  logic              tick, par_en, par_odd, stop2, rx_ie, tx_ie;
  logic [SW-1:0]     stop_last;
  logic              rx_s1, rx_sync;
  logic              ovr, perr, ferr;
  logic              unused_addr;

  assign addr        = cpu_address[4:0];
  assign unused_addr = ^cpu_address[31:5];
  assign wr_tx       = write_enable && (addr == ADDR_TXDATA);
  assign wr_ctrl     = write_enable && (addr == ADDR_CTRL);
  assign wr_status   = write_enable && (addr == ADDR_STATUS);
  assign rd_rx       = read_enable && (addr == ADDR_RXDATA);
  assign dvsr        = ctrl_q[DVSR_W-1:0];
  assign par_en      = ctrl_q[CT_PAR_EN];
  assign par_odd     = ctrl_q[CT_PAR_ODD];
  assign stop2       = ctrl_q[CT_STOP2];
  assign rx_ie       = ctrl_q[CT_RX_IE];
  assign tx_ie       = ctrl_q[CT_TX_IE];
  assign stop_last   = stop2 ? SW'(2 * SB_TICK - 1) : SW'(SB_TICK - 1);
  assign tick        = (dvsr != '0) && (baud_cnt == dvsr);

  always_ff @(posedge clk) begin
    if (reset)        ctrl_q <= '0;
    else if (wr_ctrl) ctrl_q <= cpu_data & CTRL_MASK;
  end

  // A zero divisor parks the counter, halting both FSMs
  always_ff @(posedge clk) begin
    if (reset || wr_ctrl || tick || dvsr == '0) baud_cnt <= '0;
    else                                        baud_cnt <= baud_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) {rx_sync, rx_s1} <= 2'b11;
    else       {rx_sync, rx_s1} <= {rx_s1, rx};
  end

  // ---------------- FIFOs ----------------
  logic [DBIT-1:0] tx_rdata, rx_rdata;
  logic            tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_done;
  logic [CW-1:0]   tx_count, rx_count;
  logic [DBIT-1:0] rx_shift;

  uart_sync_fifo #(.WIDTH(DBIT), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(tx_pop), .wdata(cpu_data[DBIT-1:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(DBIT), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_done), .pop(rd_rx), .wdata(rx_shift),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // ---------------- RX FSM ----------------
  rx_state_t       rx_state, rx_state_n;
  logic [SW-1:0]   rx_s, rx_s_n;
  logic [NW-1:0]   rx_n, rx_n_n;
  logic [DBIT-1:0] rx_shift_n;
  logic            rx_par, rx_par_n, rx_stop, rx_stop_n, rx_stop_lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      rx_stop  <= 1'b1;
    end else begin
      rx_state <= rx_state_n;
      rx_s     <= rx_s_n;
      rx_n     <= rx_n_n;
      rx_shift <= rx_shift_n;
      rx_par   <= rx_par_n;
      rx_stop  <= rx_stop_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_s_n     = rx_s;
    rx_n_n     = rx_n;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_stop_n  = rx_stop;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_sync) begin
        rx_state_n = RX_START;
        rx_s_n     = '0;
      end
      RX_START: if (tick) begin
        if (rx_s == SW'(BIT_TICKS/2 - 1)) begin
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          rx_s_n     = '0;
          rx_n_n     = '0;
        end else rx_s_n = rx_s + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (rx_s == SW'(BIT_TICKS - 1)) begin
          rx_s_n             = '0;
          rx_shift_n[rx_n]   = rx_sync;
          if (rx_n == NW'(DBIT - 1)) rx_state_n = par_en ? RX_PARITY : RX_STOP;
          else                       rx_n_n     = rx_n + 1'b1;
        end else rx_s_n = rx_s + 1'b1;
      end
      RX_PARITY: if (tick) begin
        if (rx_s == SW'(BIT_TICKS - 1)) begin
          rx_s_n     = '0;
          rx_par_n   = rx_sync;
          rx_state_n = RX_STOP;
        end else rx_s_n = rx_s + 1'b1;
      end
      RX_STOP: if (tick) begin
        if (rx_s == SW'(SB_TICK - 1)) rx_stop_n = rx_sync;
        if (rx_s == stop_last) begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end else rx_s_n = rx_s + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // In one-stop mode the stop sample and frame completion fall on the same tick
  assign rx_stop_lvl = (rx_s == SW'(SB_TICK - 1)) ? rx_sync : rx_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (ovr  && !(wr_status && cpu_data[ST_OVR]))  || (rx_done && rx_full && !rd_rx);
      perr <= (perr && !(wr_status && cpu_data[ST_PERR])) ||
              (rx_done && par_en && ((^{rx_shift, rx_par}) != par_odd));
      ferr <= (ferr && !(wr_status && cpu_data[ST_FERR])) || (rx_done && !rx_stop_lvl);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t       tx_state, tx_state_n;
  logic [SW-1:0]   tx_s, tx_s_n;
  logic [NW-1:0]   tx_n, tx_n_n;
  logic [DBIT-1:0] tx_data, tx_data_n;
  logic            tx_q, tx_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_data  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_s     <= tx_s_n;
      tx_n     <= tx_n_n;
      tx_data  <= tx_data_n;
      tx_q     <= tx_next;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_n_n     = tx_n;
    tx_data_n  = tx_data;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_data_n  = tx_rdata;
        tx_s_n     = '0;
        tx_state_n = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_s == SW'(BIT_TICKS - 1)) begin
          tx_s_n     = '0;
          tx_n_n     = '0;
          tx_state_n = TX_DATA;
        end else tx_s_n = tx_s + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tx_s == SW'(BIT_TICKS - 1)) begin
          tx_s_n = '0;
          if (tx_n == NW'(DBIT - 1)) tx_state_n = par_en ? TX_PARITY : TX_STOP;
          else                       tx_n_n     = tx_n + 1'b1;
        end else tx_s_n = tx_s + 1'b1;
      end
      TX_PARITY: if (tick) begin
        if (tx_s == SW'(BIT_TICKS - 1)) begin
          tx_s_n     = '0;
          tx_state_n = TX_STOP;
        end else tx_s_n = tx_s + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (tx_s == stop_last) tx_state_n = TX_IDLE;
        else                   tx_s_n     = tx_s + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Line level is registered from the next state so the pin never glitches
  always_comb begin
    case (tx_state_n)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = tx_data_n[tx_n_n];
      TX_PARITY: tx_next = (^tx_data_n) ^ par_odd;
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // ---------------- Register read and interrupt ----------------
  logic [31:0] status;

  always_comb begin
    status                       = '0;
    status[ST_TX_EMPTY]          = tx_empty;
    status[ST_TX_FULL]           = tx_full;
    status[ST_RX_EMPTY]          = rx_empty;
    status[ST_RX_FULL]           = rx_full;
    status[ST_FERR]              = ferr;
    status[ST_PERR]              = perr;
    status[ST_OVR]               = ovr;
    status[ST_RX_LEVEL +: CW]    = rx_count;
    status[ST_TX_LEVEL +: CW]    = tx_count;
  end

  always_comb begin
    case (addr)
      ADDR_RXDATA: cout = rx_empty ? 32'h0 : 32'(rx_rdata);
      ADDR_STATUS: cout = status;
      ADDR_CTRL:   cout = ctrl_q;
      default:     cout = 32'h0;
    endcase
  end

  assign irq = (rx_ie && !rx_empty) || (tx_ie && tx_empty) || ovr || perr || ferr;

endmodule
